// File: rtl/audio_dac_tx.sv
// I2S DAC transmitter: buffers one stereo pair and shifts it out MSB-first on the codec's BCLK/DACLRCK.
// Build option AUDIO_DAC_UNDERRUN_REPEAT_EN: an underrun frame re-sends the last loaded pair instead of 0/0.
`timescale 1ns/1ps
module audio_dac_tx (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [15:0] leftSampleIn,
  input  logic [15:0] rightSampleIn,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        BCLK,
  input  logic        DACLRCK,
  output logic        DACDAT,
  output logic        frame_start,
  output logic [15:0] underrun_count
);
  typedef enum logic [1:0] {WAIT_SYNC, ARM, SHIFT, PAD} state_t;
  state_t state, state_nxt;

  logic        bclk_s1, bclk_s2, bclk_d, lr_s1, lr_s2, lr_d;
  logic        bclk_fall, lr_fall, lr_rise;
  logic        hold_full, hold_full_nxt, accept;
  logic [15:0] hold_l, hold_r, sh_l, sh_r, ur_l, ur_r, cur_word;
  logic        sel_r, sel_nxt, dat_nxt;
  logic [3:0]  bit_cnt, cnt_nxt, cnt_dec;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      {bclk_s1, bclk_s2, bclk_d} <= 3'b000;
      {lr_s1, lr_s2, lr_d}       <= 3'b000;
    end else begin
      bclk_s1 <= BCLK;    bclk_s2 <= bclk_s1; bclk_d <= bclk_s2;
      lr_s1   <= DACLRCK; lr_s2   <= lr_s1;   lr_d   <= lr_s2;
    end
  end

  assign bclk_fall = bclk_d & ~bclk_s2;
  assign lr_fall   = lr_d & ~lr_s2;
  assign lr_rise   = ~lr_d & lr_s2;

  // Load decisions use hold_full as it was before this edge, so a same-cycle accept waits a frame.
  assign accept        = sample_valid & sample_ready;
  assign hold_full_nxt = accept | (hold_full & ~lr_fall);
  assign cur_word      = sel_r ? sh_r : sh_l;
  assign cnt_dec       = bit_cnt - 4'd1;

`ifdef AUDIO_DAC_UNDERRUN_REPEAT_EN
  logic [15:0] last_l, last_r;
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      last_l <= '0;
      last_r <= '0;
    end else if (lr_fall && hold_full) begin
      last_l <= hold_l;
      last_r <= hold_r;
    end
  end
  assign ur_l = last_l;
  assign ur_r = last_r;
`else
  assign ur_l = '0;
  assign ur_r = '0;
`endif

  always_comb begin
    state_nxt = state;
    dat_nxt   = DACDAT;
    cnt_nxt   = bit_cnt;
    sel_nxt   = sel_r;
    if (lr_fall) begin
      // Left frame edge is honoured in every state; it also aborts a short word.
      sel_nxt   = 1'b0;
      dat_nxt   = 1'b0;
      state_nxt = ARM;
    end else if (lr_rise && state != WAIT_SYNC) begin
      sel_nxt   = 1'b1;
      dat_nxt   = 1'b0;
      state_nxt = ARM;
    end else if (bclk_fall) begin
      case (state)
        ARM: begin
          dat_nxt   = cur_word[15];
          cnt_nxt   = 4'd15;
          state_nxt = SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == 4'd0) begin
            dat_nxt   = 1'b0;
            state_nxt = PAD;
          end else begin
            dat_nxt = cur_word[cnt_dec];
            cnt_nxt = cnt_dec;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= WAIT_SYNC;
      DACDAT       <= 1'b0;
      bit_cnt      <= '0;
      sel_r        <= 1'b0;
      frame_start  <= 1'b0;
      hold_full    <= 1'b0;
      sample_ready <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      sh_l         <= '0;
      sh_r         <= '0;
    end else begin
      state        <= state_nxt;
      DACDAT       <= dat_nxt;
      bit_cnt      <= cnt_nxt;
      sel_r        <= sel_nxt;
      frame_start  <= lr_fall;
      hold_full    <= hold_full_nxt;
      sample_ready <= ~hold_full_nxt;
      if (accept) begin
        hold_l <= leftSampleIn;
        hold_r <= rightSampleIn;
      end
      if (lr_fall) begin
        sh_l <= hold_full ? hold_l : ur_l;
        sh_r <= hold_full ? hold_r : ur_r;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)
      underrun_count <= '0;
    else if (lr_fall && !hold_full && underrun_count != 16'hFFFF)
      underrun_count <= underrun_count + 16'd1;
  end
endmodule
